// File: rtl/dma_xfer_ctrl.sv
// DMA transfer sequencer: holds channel configuration, drives the cascaded address
// counter chain and handshakes each word with the requesting device.
module dma_xfer_ctrl #(
    parameter int unsigned AW  = 4,
    parameter int unsigned WCW = 8,
    parameter int unsigned CW  = 8
) (
    input  logic           clk,
    input  logic           res,
    input  logic           cfg_we,
    input  logic [1:0]     cfg_sel,
    input  logic [CW-1:0]  cfg_data,
    input  logic           start,
    input  logic           abort,
    input  logic           dreq,
    output logic           dack,
    output logic           addr_load,
    output logic [AW-1:0]  addr_data,
    output logic           addr_en,
    output logic           addr_up,
    output logic           busy,
    output logic           done,
    output logic           tc,
    output logic [WCW-1:0] wc_rem
);

    localparam int unsigned CTRLW = 3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_WAIT = 3'd2,
        S_XFER = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CTRLW-1:0] ctrl_q, ctrl_d;
    logic [AW-1:0]    base_q, base_d;
    logic [WCW-1:0]   wc_shadow_q, wc_shadow_d;
    logic [WCW-1:0]   wc_rem_q, wc_rem_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             dack_q, dack_d;
    logic             addr_load_q, addr_load_d;
    logic             addr_en_q, addr_en_d;
    logic             done_q, done_d;
    logic             last_word;

    assign last_word = (wc_rem_q == WCW'(1));

    // State and all registered outputs
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q     <= S_IDLE;
            ctrl_q      <= '0;
            base_q      <= '0;
            wc_shadow_q <= '0;
            wc_rem_q    <= '0;
            tc_q        <= 1'b0;
            busy_q      <= 1'b0;
            dack_q      <= 1'b0;
            addr_load_q <= 1'b0;
            addr_en_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_q      <= ctrl_d;
            base_q      <= base_d;
            wc_shadow_q <= wc_shadow_d;
            wc_rem_q    <= wc_rem_d;
            tc_q        <= tc_d;
            busy_q      <= busy_d;
            dack_q      <= dack_d;
            addr_load_q <= addr_load_d;
            addr_en_q   <= addr_en_d;
            done_q      <= done_d;
        end
    end

    // Configuration writes (IDLE only) and remaining word count
    always_comb begin
        ctrl_d      = ctrl_q;
        base_d      = base_q;
        wc_shadow_d = wc_shadow_q;
        wc_rem_d    = wc_rem_q;
        if (state_q == S_IDLE && cfg_we) begin
            unique case (cfg_sel)
                2'd0:    ctrl_d = cfg_data[CTRLW-1:0];
                2'd1: begin
                    wc_shadow_d = cfg_data[WCW-1:0];
                    wc_rem_d    = cfg_data[WCW-1:0];
                end
                2'd2:    base_d = cfg_data[AW-1:0];
                default: ;
            endcase
        end else if (state_q == S_XFER) begin
            if (last_word && ctrl_q[1] && !abort) begin
                wc_rem_d = wc_shadow_q;
            end else if (wc_rem_q != '0) begin
                wc_rem_d = wc_rem_q - WCW'(1);
            end
        end
    end

    // Next-state logic; start decision sees a same-cycle word-count write
    always_comb begin
        state_d = state_q;
        tc_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (wc_shadow_d != '0) ? S_LOAD : S_DONE;
                end
            end
            S_LOAD: state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort)     state_d = S_IDLE;
                else if (dreq) state_d = S_XFER;
            end
            S_XFER: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (last_word) begin
                    state_d = ctrl_q[1] ? S_LOAD : S_DONE;
                    tc_d    = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the upcoming state, then registered
    always_comb begin
        busy_d      = 1'b0;
        dack_d      = 1'b0;
        addr_load_d = 1'b0;
        addr_en_d   = 1'b0;
        done_d      = 1'b0;
        unique case (state_d)
            S_LOAD: begin
                busy_d      = 1'b1;
                addr_load_d = 1'b1;
            end
            S_WAIT: busy_d = 1'b1;
            S_XFER: begin
                busy_d    = 1'b1;
                dack_d    = 1'b1;
                addr_en_d = !ctrl_d[2];
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign dack      = dack_q;
    assign addr_load = addr_load_q;
    assign addr_data = base_q;
    assign addr_en   = addr_en_q;
    assign addr_up   = ctrl_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign tc        = tc_q;
    assign wc_rem    = wc_rem_q;

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Self-checking bench for dma_xfer_ctrl: directed steps plus randomized runs
// checked against a per-run transaction model and an attached counter model.
module tb_dma_xfer_ctrl;

    localparam int unsigned AW  = 4;
    localparam int unsigned WCW = 8;
    localparam int unsigned CW  = 8;

    logic           clk = 1'b0;
    logic           res = 1'b0;
    logic           cfg_we = 1'b0;
    logic [1:0]     cfg_sel = '0;
    logic [CW-1:0]  cfg_data = '0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic           dreq = 1'b0;
    logic           dack, addr_load, addr_en, addr_up, busy, done, tc;
    logic [AW-1:0]  addr_data;
    logic [WCW-1:0] wc_rem;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dma_xfer_ctrl #(.AW(AW), .WCW(WCW), .CW(CW)) dut (
        .clk(clk), .res(res), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .start(start), .abort(abort), .dreq(dreq), .dack(dack), .addr_load(addr_load),
        .addr_data(addr_data), .addr_en(addr_en), .addr_up(addr_up), .busy(busy),
        .done(done), .tc(tc), .wc_rem(wc_rem)
    );

    // Attached counter chain and event counters, sampled at each edge
    logic [AW-1:0] ctr = '0;
    int dack_cnt = 0, load_cnt = 0, tc_cnt = 0, done_cnt = 0, viol = 0;
    logic prev_dreq = 1'b0, prev_dack = 1'b0;

    always @(posedge clk) begin
        if (dack)      dack_cnt <= dack_cnt + 1;
        if (addr_load) load_cnt <= load_cnt + 1;
        if (tc)        tc_cnt   <= tc_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
        if (addr_load)    ctr <= addr_data;
        else if (addr_en) ctr <= addr_up ? ctr + 1'b1 : ctr - 1'b1;
        if (dack && (!prev_dreq || prev_dack)) viol <= viol + 1;
        prev_dreq <= dreq;
        prev_dack <= dack;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_wr(input logic [1:0] sel, input logic [CW-1:0] d);
        cfg_we = 1'b1; cfg_sel = sel; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, 32'(done), 1);
    endtask

    initial begin
        int nd, k, d0, l0, t0, c0;
        logic [2:0]    r_ctrl;
        logic [AW-1:0] r_base, exp_ctr;
        logic [WCW-1:0] r_wc;

        // 1. Reset with random inputs
        repeat (2) begin
            cfg_we = 1'($urandom); cfg_sel = 2'($urandom); cfg_data = CW'($urandom);
            start = 1'($urandom); abort = 1'($urandom); dreq = 1'($urandom);
            tick();
        end
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_tc", 32'(tc), 0);
        chk("rst_dack", 32'(dack), 0);
        chk("rst_load", 32'(addr_load), 0);
        chk("rst_en", 32'(addr_en), 0);
        chk("rst_wc", 32'(wc_rem), 0);
        chk("rst_up", 32'(addr_up), 0);
        chk("rst_data", 32'(addr_data), 0);
        cfg_we = 0; start = 0; abort = 0; dreq = 0;
        res = 1'b1;
        tick();

        // 2. Basic up run, dreq held high
        cfg_wr(2'd0, 8'h01); cfg_wr(2'd2, 8'h0A); cfg_wr(2'd1, 8'd3);
        dreq = 1; start = 1; tick(); start = 0;
        chk("t2_load", 32'(addr_load), 1);
        chk("t2_addr", 32'(addr_data), 32'hA);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t2_dack", 32'(dack), 32'(i % 2));
            if (i % 2 == 1) begin
                chk("t2_en", 32'(addr_en), 1);
                chk("t2_wc", 32'(wc_rem), 32'(3 - i / 2));
            end
        end
        tick();
        chk("t2_done", 32'(done), 1);
        chk("t2_tc", 32'(tc), 1);
        chk("t2_wc_end", 32'(wc_rem), 0);
        dreq = 0;
        tick();
        chk("t2_ctr", 32'(ctr), 32'hD);
        chk("t2_done_off", 32'(done), 0);

        // 3. Down run with request gaps
        cfg_wr(2'd0, 8'h00); cfg_wr(2'd2, 8'h05); cfg_wr(2'd1, 8'd2);
        d0 = done_cnt;
        start = 1; tick(); start = 0;
        for (int w = 0; w < 2; w++) begin
            repeat (4) begin
                tick();
                chk("t3_nodack", 32'(dack), 0);
            end
            dreq = 1;
            k = 0;
            while (dack !== 1'b1 && k < 10) begin tick(); k++; end
            chk("t3_dack", 32'(dack), 1);
            dreq = 0;
        end
        wait_done("t3", 20);
        tick();
        chk("t3_ctr", 32'(ctr), 32'h3);
        chk("t3_done_once", 32'(done_cnt - d0), 1);

        // 4. Auto-reinitialise, abort after five words
        cfg_wr(2'd0, 8'h02); cfg_wr(2'd1, 8'd2);
        t0 = tc_cnt;
        dreq = 1; start = 1; tick(); start = 0;
        nd = 0; k = 0;
        while (nd < 5 && k < 60) begin
            tick(); k++;
            if (tc) begin
                chk("t4_tc_load", 32'(addr_load), 1);
                chk("t4_tc_phase", 32'(nd % 2), 0);
                chk("t4_reload", 32'(wc_rem), 2);
            end
            if (dack) nd++;
        end
        chk("t4_dacks", 32'(nd), 5);
        abort = 1; tick(); abort = 0; dreq = 0;
        chk("t4_ab_busy", 32'(busy), 0);
        chk("t4_ab_done", 32'(done), 0);
        chk("t4_ab_wc", 32'(wc_rem), 1);
        tick();
        chk("t4_ab_done2", 32'(done), 0);
        chk("t4_tc_cnt", 32'(tc_cnt - t0), 2);

        // 5a. Zero word count
        cfg_wr(2'd0, 8'h01); cfg_wr(2'd1, 8'd0);
        l0 = load_cnt; t0 = tc_cnt;
        start = 1; tick(); start = 0;
        chk("t5_z_done", 32'(done), 1);
        chk("t5_z_tc", 32'(tc), 0);
        chk("t5_z_load", 32'(addr_load), 0);
        tick();
        chk("t5_z_loads", 32'(load_cnt - l0), 0);
        chk("t5_z_tcs", 32'(tc_cnt - t0), 0);
        chk("t5_z_off", 32'(done), 0);

        // 5b. Hold mode, cfg write and start while busy
        cfg_wr(2'd0, 8'h05); cfg_wr(2'd2, 8'h03); cfg_wr(2'd1, 8'd2);
        d0 = dack_cnt;
        dreq = 1; start = 1; tick(); start = 0;
        cfg_we = 1; cfg_sel = 2'd2; cfg_data = 8'h0C; tick(); cfg_we = 0;
        start = 1;
        k = 0;
        while (done !== 1'b1 && k < 20) begin
            tick(); k++;
            if (dack) chk("t5_hold_en", 32'(addr_en), 0);
        end
        start = 0; dreq = 0;
        chk("t5_h_done", 32'(done), 1);
        chk("t5_h_base", 32'(addr_data), 32'h3);
        tick();
        chk("t5_h_idle", 32'(busy), 0);
        chk("t5_h_dacks", 32'(dack_cnt - d0), 2);
        chk("t5_h_ctr", 32'(ctr), 32'h3);

        // 6. Reset during a transfer
        cfg_wr(2'd0, 8'h01); cfg_wr(2'd1, 8'd3);
        dreq = 1; start = 1; tick(); start = 0;
        k = 0;
        while (dack !== 1'b1 && k < 10) begin tick(); k++; end
        chk("t6_in_xfer", 32'(dack), 1);
        res = 0; tick(); res = 1; dreq = 0;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_dack", 32'(dack), 0);
        chk("t6_en", 32'(addr_en), 0);
        chk("t6_done", 32'(done), 0);
        chk("t6_wc", 32'(wc_rem), 0);
        chk("t6_data", 32'(addr_data), 0);
        tick();
        chk("t6_done2", 32'(done), 0);

        // 7. Randomized runs against the per-run model
        for (int r = 0; r < 24; r++) begin
            r_ctrl = {1'($urandom), 1'b0, 1'($urandom)};
            r_base = AW'($urandom);
            r_wc   = WCW'($urandom_range(1, 6));
            cfg_wr(2'd0, CW'(r_ctrl)); cfg_wr(2'd2, CW'(r_base)); cfg_wr(2'd1, CW'(r_wc));
            d0 = dack_cnt; l0 = load_cnt; t0 = tc_cnt; c0 = done_cnt;
            start = 1; tick(); start = 0;
            k = 0;
            while (done !== 1'b1 && k < 300) begin
                dreq = 1'($urandom); start = 1'($urandom);
                cfg_we = ($urandom_range(0, 3) == 0); cfg_sel = 2'($urandom);
                cfg_data = CW'($urandom);
                tick(); k++;
            end
            cfg_we = 0; start = 0; dreq = 0;
            chk("rnd_done_seen", 32'(done), 1);
            tick();
            if (r_ctrl[2])      exp_ctr = r_base;
            else if (r_ctrl[0]) exp_ctr = AW'(r_base + AW'(r_wc));
            else                exp_ctr = AW'(r_base - AW'(r_wc));
            chk("rnd_dacks", 32'(dack_cnt - d0), 32'(r_wc));
            chk("rnd_loads", 32'(load_cnt - l0), 1);
            chk("rnd_tcs", 32'(tc_cnt - t0), 1);
            chk("rnd_dones", 32'(done_cnt - c0), 1);
            chk("rnd_ctr", 32'(ctr), 32'(exp_ctr));
            chk("rnd_wc", 32'(wc_rem), 0);
        end
        chk("handshake_rules", 32'(viol), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dma_xfer_ctrl.md
Name: dma_xfer_ctrl

Overview:
- Transfer sequencer for the DMA address generator.
- Holds the channel configuration: base address, word count and control bits.
- Drives load/enable/direction of the cascaded address counter chain, built from the 4-bit up/down counter slices.
- Tracks the remaining word count internally and handshakes each transfer with the requesting device (dreq/dack).
- Signals completion with a done pulse, or re-arms itself in auto-reinitialise mode.

Parameters:
- AW, 4: address counter width. Multiple of 4 (one counter slice per nibble).
- WCW, 8: word count width.
- CW, 8: configuration data bus width. Must satisfy CW >= AW and CW >= WCW.

Ports:
- clk, input, 1: clock, rising edge.
- res, input, 1: synchronous, active-low reset.
- cfg_we, input, 1: configuration write strobe.
- cfg_sel, input, 2: write target. 0 = control, 1 = word count, 2 = base address, 3 = no effect.
- cfg_data, input, CW: write data. The LSBs are used.
- start, input, 1: start a channel run (level sampled in IDLE).
- abort, input, 1: terminate the run.
- dreq, input, 1: device transfer request.
- dack, output, 1: transfer acknowledge, one cycle per word.
- addr_load, output, 1: counter-chain load.
- addr_data, output, AW: counter-chain load value. Always equals the base register.
- addr_en, output, 1: counter-chain enable.
- addr_up, output, 1: counter-chain direction (ctrl[0]).
- busy, output, 1: run in progress.
- done, output, 1: one-cycle completion pulse.
- tc, output, 1: one-cycle terminal-count pulse.
- wc_rem, output, WCW: remaining word count.

Behaviour:
- Reset (res=0 at a clk edge):
  - ctrl, base, wc_shadow and wc_rem are cleared to 0; state goes to IDLE.
  - All outputs are 0, including addr_up and addr_data.
  - Reset overrides every other input and aborts a run mid-transfer.
- Control register bits:
  - ctrl[0]: address direction, 1 = up.
  - ctrl[1]: auto-reinitialise.
  - ctrl[2]: address hold. While set, addr_en is never asserted.
- Configuration writes:
  - Accepted only in IDLE; ignored in every other state.
  - A word-count write loads both wc_shadow and wc_rem.
  - A write in the same cycle as start takes effect and is used by that run.
- States, with Moore outputs:
  - IDLE: busy=0. Next state:
    - start=1 and wc_shadow != 0 -> LOAD.
    - start=1 and wc_shadow == 0 -> DONE. No addr_load and no dack are issued.
    - otherwise stay in IDLE.
  - LOAD: busy=1, addr_load=1. Next state -> WAIT.
  - WAIT: busy=1. Next state -> XFER if dreq=1, else stay in WAIT.
  - XFER: busy=1, dack=1, addr_en = !ctrl[2]. At the exiting edge wc_rem decrements by 1. Next state:
    - wc_rem != 1 -> WAIT.
    - wc_rem == 1 and ctrl[1]=0 -> DONE. tc=1 in the DONE cycle.
    - wc_rem == 1 and ctrl[1]=1 -> LOAD. wc_rem reloads from wc_shadow instead of going to 0; tc=1 in that LOAD cycle.
  - DONE: busy=0, done=1. Next state -> IDLE.
- tc and done:
  - tc is registered and asserted for exactly one cycle per exhausted word count.
  - tc=0 for a zero-count run.
- Throughput: a minimum of 2 cycles per word (XFER, then WAIT). dreq held high gives dack on alternate cycles.
- Abort:
  - In LOAD, WAIT or XFER, abort=1 forces next state = IDLE with no done and no tc.
  - The current cycle's Moore outputs still occur, so an XFER in progress completes its word and wc_rem decrements.
  - wc_rem keeps its partial value after abort.
  - Abort is ignored in IDLE and DONE.
- start while not in IDLE is ignored.
- Latency: start edge -> addr_load in the next cycle. The first dack comes no earlier than 2 cycles after addr_load.
- Auto mode runs indefinitely until abort or reset.
- Width: wc_rem never wraps below 0. There are no transfers with count 0.

Test Plan:
1. Reset: hold res=0 for 2 cycles with random inputs -> busy=0, done=0, tc=0, dack=0, addr_load=0, addr_en=0, wc_rem=0.
2. Basic up run: write ctrl=3'b001, base=4'b1010, wc=3; pulse start; hold dreq=1.
   - addr_load one cycle later with addr_data=1010.
   - dack/addr_en on 3 alternate cycles; wc_rem goes 3->2->1->0.
   - The DONE cycle has done=1 and tc=1.
   - The attached counter ends at 1101.
3. Down run with gaps: ctrl=3'b000, base=4'b0101, wc=2, dreq low for 4 cycles before each request.
   - No dack while dreq=0.
   - Counter ends at 0011; done pulses once.
4. Auto-reinit: ctrl=3'b010, wc=2, dreq=1.
   - tc pulses every 2 dacks, each coinciding with addr_load.
   - wc_rem reloads to 2.
   - Abort after 5 dacks -> IDLE next cycle, no done, wc_rem=1.
5. Boundaries:
   - wc=0 with start -> done one cycle later, tc=0, no addr_load.
   - Hold mode ctrl[2]=1 -> dack pulses with addr_en=0.
   - cfg write while busy -> register unchanged.
   - start while busy -> ignored.
6. Reset mid-run: drive res=0 during an XFER cycle -> next cycle IDLE, all outputs 0, wc_rem=0, no done.
